// File: rtl/im_loader.sv
// Boot-time instruction loader. It receives a length-prefixed, XOR-protected
// byte stream, assembles big-endian 32-bit words and writes them into
// instruction memory. The core is held in reset until the image is verified.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LEN_HI | waiting for the upper byte of the word count
// S_LEN_LO | waiting for the lower byte; range check on the full count
// S_DATA   | collecting payload bytes, one IM write per 4 bytes
// S_CHK    | waiting for the checksum byte
// S_DONE   | image verified, core released (terminal until reset)
// S_ERR    | image rejected, core stays in reset (terminal until reset)
module im_loader #(
    parameter int DEPTH = 64
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        IMWE,
    output logic [31:0] IMWA,
    output logic [31:0] IMWD,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  xor_q, xor_d;
    logic        imwe_q, imwe_d;
    logic [31:0] imwa_q, imwa_d;
    logic [31:0] imwd_q, imwd_d;

    logic        accept;
    logic [15:0] n_len;

    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
    assign accept   = in_valid && in_ready;
    assign n_len    = {len_q[15:8], in_data};

    assign IMWE     = imwe_q;
    assign IMWA     = imwa_q;
    assign IMWD     = imwd_q;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign core_rst = done;

    // Next-state, word assembly, running checksum and IM write generation.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        xor_d   = xor_q;
        imwe_d  = 1'b0;
        imwa_d  = imwa_q;
        imwd_d  = imwd_q;

        // The checksum byte itself is compared, not folded in.
        if (accept && (state_q != S_CHK)) begin
            xor_d = xor_q ^ in_data;
        end

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = n_len;
                    if (n_len > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (n_len == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        idx_d   = 16'd0;
                        bcnt_d  = 2'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d = {shift_q[15:0], in_data};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        imwe_d = 1'b1;
                        imwa_d = {14'd0, idx_q, 2'b00};
                        imwd_d = {shift_q, in_data};
                        idx_d  = idx_q + 16'd1;
                        if (idx_q == (len_q - 16'd1)) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= S_LEN_HI;
            len_q   <= 16'd0;
            idx_q   <= 16'd0;
            bcnt_q  <= 2'd0;
            shift_q <= 24'd0;
            xor_q   <= 8'd0;
            imwe_q  <= 1'b0;
            imwa_q  <= 32'd0;
            imwd_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            xor_q   <= xor_d;
            imwe_q  <= imwe_d;
            imwa_q  <= imwa_d;
            imwd_q  <= imwd_d;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: single/two-word loads, checksum failure,
// oversize and empty images, and reset in the middle of a frame.
module tb_im_loader;

    logic        CLK;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        IMWE;
    logic [31:0] IMWA;
    logic [31:0] IMWD;
    logic        core_rst;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cnt = 0;
    int          base;

    im_loader #(.DEPTH(64)) dut (
        .CLK      (CLK),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .IMWE     (IMWE),
        .IMWA     (IMWA),
        .IMWD     (IMWD),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Log every IM write, sampled mid-cycle.
    always @(negedge CLK) begin
        if (IMWE === 1'b1 && wr_cnt < 64) begin
            wr_addr[wr_cnt] = IMWA;
            wr_data[wr_cnt] = IMWD;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles; returns #1 after the edge that takes it.
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_imwe",     32'(IMWE),     32'd0);
        check("rst_imwa",     IMWA,          32'd0);
        check("rst_imwd",     IMWD,          32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        repeat (2) @(negedge CLK);
        rst = 1'b1;

        // Single word: 00 01 20 08 00 05 2C
        base = wr_cnt;
        send(8'h00, 0); send(8'h01, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0);
        check("w1_pre_imwe", 32'(IMWE), 32'd0);
        send(8'h05, 0);
        check("w1_imwe", 32'(IMWE), 32'd1);
        check("w1_imwa", IMWA, 32'h0000_0000);
        check("w1_imwd", IMWD, 32'h2008_0005);
        check("w1_not_done", 32'(done), 32'd0);
        send(8'h2C, 0);
        check("w1_done",     32'(done),     32'd1);
        check("w1_core_rst", 32'(core_rst), 32'd1);
        check("w1_err",      32'(err),      32'd0);
        check("w1_in_ready", 32'(in_ready), 32'd0);
        check("w1_imwd_hold", IMWD, 32'h2008_0005);
        check("w1_wr_cnt", 32'(wr_cnt - base), 32'd1);

        // Two words with random idle gaps; checksum 0x05
        do_reset();
        base = wr_cnt;
        send(8'h00, $urandom_range(0, 3)); send(8'h02, $urandom_range(0, 3));
        send(8'h20, $urandom_range(0, 3)); send(8'h08, $urandom_range(0, 3));
        send(8'h00, $urandom_range(0, 3)); send(8'h05, $urandom_range(0, 3));
        send(8'h20, $urandom_range(0, 3)); send(8'h09, $urandom_range(0, 3));
        send(8'h00, $urandom_range(0, 3)); send(8'h03, $urandom_range(0, 3));
        send(8'h05, $urandom_range(0, 3));
        @(negedge CLK);
        check("w2_wr_cnt", 32'(wr_cnt - base), 32'd2);
        check("w2_a0", wr_addr[base],     32'h0000_0000);
        check("w2_d0", wr_data[base],     32'h2008_0005);
        check("w2_a1", wr_addr[base + 1], 32'h0000_0004);
        check("w2_d1", wr_data[base + 1], 32'h2009_0003);
        check("w2_done",     32'(done),     32'd1);
        check("w2_in_ready", 32'(in_ready), 32'd0);

        // Bad checksum
        do_reset();
        base = wr_cnt;
        send(8'h00, 0); send(8'h01, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        send(8'h2D, 0);
        check("bad_err",      32'(err),      32'd1);
        check("bad_done",     32'(done),     32'd0);
        check("bad_core_rst", 32'(core_rst), 32'd0);
        check("bad_in_ready", 32'(in_ready), 32'd0);
        check("bad_wr_cnt", 32'(wr_cnt - base), 32'd1);
        check("bad_wd", wr_data[base], 32'h2008_0005);

        // Oversize: N = 65
        do_reset();
        base = wr_cnt;
        send(8'h00, 0); send(8'h41, 0);
        check("big_err",      32'(err),      32'd1);
        check("big_in_ready", 32'(in_ready), 32'd0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        send(8'h00, 0); send(8'h00, 0);
        check("big_err_hold", 32'(err),  32'd1);
        check("big_done",     32'(done), 32'd0);
        check("big_imwe",     32'(IMWE), 32'd0);
        check("big_wr_cnt", 32'(wr_cnt - base), 32'd0);

        // Boundary: N = 64 is accepted into the data phase
        do_reset();
        send(8'h00, 0); send(8'h40, 0);
        check("n64_err",      32'(err),      32'd0);
        check("n64_in_ready", 32'(in_ready), 32'd1);

        // Empty image, good and bad checksum
        do_reset();
        base = wr_cnt;
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_err",  32'(err),  32'd0);
        check("empty_wr_cnt", 32'(wr_cnt - base), 32'd0);
        do_reset();
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
        check("empty_bad_err",  32'(err),  32'd1);
        check("empty_bad_done", 32'(done), 32'd0);

        // Reset after the 2nd payload byte of a 2-word frame
        do_reset();
        base = wr_cnt;
        send(8'h00, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_imwe",     32'(IMWE),     32'd0);
        check("mid_imwa",     IMWA,          32'd0);
        check("mid_imwd",     IMWD,          32'd0);
        check("mid_core_rst", 32'(core_rst), 32'd0);
        check("mid_done",     32'(done),     32'd0);
        check("mid_err",      32'(err),      32'd0);
        @(negedge CLK);
        rst = 1'b1;
        send(8'h00, 0); send(8'h01, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        send(8'h2C, 0);
        @(negedge CLK);
        check("mid_wr_cnt", 32'(wr_cnt - base), 32'd1);
        check("mid_wa", wr_addr[base], 32'h0000_0000);
        check("mid_wd", wr_data[base], 32'h2008_0005);
        check("mid_done_after", 32'(done), 32'd1);
        check("mid_core_rst_after", 32'(core_rst), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
